// File: rtl/dff_test_pkg.sv
// Shared definitions for the DFF scan-chain test path: state encodings for the
// PISO readout sequencer and the default frame geometry that the downstream
// error-capture stage also relies on.
package dff_test_pkg;

  // Default frame geometry (bits per chain, CLK cycles per shift half-period,
  // CLK cycles of parallel load).
  localparam int CHAIN_LEN_DEF   = 256;
  localparam int DIV_DEF         = 4;
  localparam int LOAD_CYCLES_DEF = 2;

  // 3-bit state encodings.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_LOW  = 3'd2;
  localparam logic [2:0] S_HIGH = 3'd3;
  localparam logic [2:0] S_SAVE = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_LOAD = S_LOAD,
    ST_LOW  = S_LOW,
    ST_HIGH = S_HIGH,
    ST_SAVE = S_SAVE,
    ST_DONE = S_DONE
  } piso_state_t;

  // Larger of two integers; used to size counters shared by several phases.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector. The rise output is a one-cycle pulse three CLK cycles
// after the input goes high.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Synchronize din, remember the previous synchronized value, register the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      rise    <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/piso_readout_seq.sv
// PISO readout sequencer: on a start request it pulses the chip's parallel
// load, then toggles shift_clk once per bit, strobing each bit into the FPGA
// with its index, and ends each frame with a save pulse. Frames can repeat
// back-to-back in continuous mode; abort returns to idle at once.
module piso_readout_seq
  import dff_test_pkg::*;
#(
  parameter int CHAIN_LEN   = CHAIN_LEN_DEF,
  parameter int DIV         = DIV_DEF,
  parameter int LOAD_CYCLES = LOAD_CYCLES_DEF,
  parameter int IDX_W       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  output logic             load,
  output logic             shift_clk,
  output logic             sample_strb,
  output logic [IDX_W-1:0] bit_idx,
  output logic             save_data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt
);

  // Phase counter covers the longest timed state (a shift half-period or load).
  localparam int PH_W = $clog2(max2(DIV, LOAD_CYCLES) + 1);

  // Reload values: the counter counts down and the state ends when it reaches 0.
  localparam logic [PH_W-1:0]  DIV_LAST  = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]  LOAD_LAST = PH_W'(LOAD_CYCLES - 1);
  localparam logic [IDX_W-1:0] K_LAST    = IDX_W'(CHAIN_LEN - 1);

  logic start_rise;

  piso_state_t      state_q;
  piso_state_t      state_nxt;
  logic [PH_W-1:0]  phase_q;
  logic [PH_W-1:0]  phase_nxt;
  logic [IDX_W-1:0] k_q;
  logic [IDX_W-1:0] k_nxt;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_nxt;

  logic             load_nxt;
  logic             shift_nxt;
  logic             strb_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             save_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  sync_edge_detect u_start_sync (
    .clk  (CLK),
    .rst  (RST),
    .din  (start),
    .rise (start_rise)
  );

  assign frame_cnt = cnt_q;

  // Next state, phase counter, bit counter and frame counter; abort overrides all.
  always_comb begin
    state_nxt = state_q;
    phase_nxt = (phase_q != '0) ? phase_q - 1'b1 : '0;
    k_nxt     = k_q;
    cnt_nxt   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_nxt = ST_LOAD;
          phase_nxt = LOAD_LAST;
        end
      end
      ST_LOAD: begin
        if (phase_q == '0) begin
          state_nxt = ST_LOW;
          phase_nxt = DIV_LAST;
          k_nxt     = '0;
        end
      end
      ST_LOW: begin
        if (phase_q == '0) begin
          if (k_q < K_LAST) begin
            state_nxt = ST_HIGH;
            phase_nxt = DIV_LAST;
          end else begin
            // Frame counter moves together with the save pulse.
            state_nxt = ST_SAVE;
            phase_nxt = '0;
            cnt_nxt   = cnt_q + 16'd1;
          end
        end
      end
      ST_HIGH: begin
        if (phase_q == '0) begin
          state_nxt = ST_LOW;
          phase_nxt = DIV_LAST;
          k_nxt     = k_q + 1'b1;
        end
      end
      ST_SAVE: begin
        if (continuous) begin
          state_nxt = ST_LOAD;
          phase_nxt = LOAD_LAST;
        end else begin
          state_nxt = ST_DONE;
          phase_nxt = '0;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        phase_nxt = '0;
        k_nxt     = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        phase_nxt = '0;
        k_nxt     = '0;
      end
    endcase

    // A started frame is dropped without save, done or count.
    if (abort && (state_q != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      phase_nxt = '0;
      k_nxt     = '0;
      cnt_nxt   = cnt_q;
    end
  end

  // Output values for the upcoming cycle, decoded from the next state so every pin is a flop.
  always_comb begin
    load_nxt  = (state_nxt == ST_LOAD);
    shift_nxt = (state_nxt == ST_HIGH);
    strb_nxt  = (state_nxt == ST_LOW) && (phase_nxt == '0);
    idx_nxt   = ((state_nxt == ST_LOW) || (state_nxt == ST_HIGH)) ? k_nxt : '0;
    save_nxt  = (state_nxt == ST_SAVE);
    busy_nxt  = (state_nxt != ST_IDLE);
    done_nxt  = (state_nxt == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      load        <= 1'b0;
      shift_clk   <= 1'b0;
      sample_strb <= 1'b0;
      bit_idx     <= '0;
      save_data   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      phase_q     <= phase_nxt;
      k_q         <= k_nxt;
      cnt_q       <= cnt_nxt;
      load        <= load_nxt;
      shift_clk   <= shift_nxt;
      sample_strb <= strb_nxt;
      bit_idx     <= idx_nxt;
      save_data   <= save_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_piso_readout_seq.sv
// Bench for piso_readout_seq: scenario table, hand-written corner sequences and
// randomized frames, all checked against an event schedule computed from the
// frame timing rules.
module tb_piso_readout_seq;

  localparam int CL = 4;
  localparam int DV = 2;
  localparam int LC = 2;
  localparam int IW = 2;
  localparam int FL = LC + CL * DV + (CL - 1) * DV + 1;  // 17 cycles per frame

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          continuous;
  logic          abort;
  logic          load;
  logic          shift_clk;
  logic          sample_strb;
  logic [IW-1:0] bit_idx;
  logic          save_data;
  logic          busy;
  logic          done;
  logic [15:0]   frame_cnt;

  logic          start1;
  logic          load1;
  logic          shift1;
  logic          strb1;
  logic [0:0]    idx1;
  logic          save1;
  logic          busy1;
  logic          done1;
  logic [15:0]   cnt1;
  logic          zero1 = 1'b0;

  piso_readout_seq #(.CHAIN_LEN(CL), .DIV(DV), .LOAD_CYCLES(LC)) dut (
    .CLK(CLK), .RST(RST), .start(start), .continuous(continuous), .abort(abort),
    .load(load), .shift_clk(shift_clk), .sample_strb(sample_strb), .bit_idx(bit_idx),
    .save_data(save_data), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  piso_readout_seq #(.CHAIN_LEN(1), .DIV(DV), .LOAD_CYCLES(LC)) dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .continuous(zero1), .abort(zero1),
    .load(load1), .shift_clk(shift1), .sample_strb(strb1), .bit_idx(idx1),
    .save_data(save1), .busy(busy1), .done(done1), .frame_cnt(cnt1)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Event kinds: 0 load cycle, 1 sample strobe (v = bit index), 2 shift_clk rise, 3 save, 4 done.
  typedef struct { int k; int t; int v; } ev_t;
  ev_t  act_q[$];
  ev_t  exp_q[$];
  int   n_k[5];
  logic shift_d = 1'b0;

  always @(negedge CLK) begin
    if (load)                  act_q.push_back('{0, cyc, 0});
    if (sample_strb)           act_q.push_back('{1, cyc, int'(bit_idx)});
    if (shift_clk && !shift_d) act_q.push_back('{2, cyc, 0});
    if (save_data)             act_q.push_back('{3, cyc, 0});
    if (done)                  act_q.push_back('{4, cyc, 0});
    shift_d = shift_clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add_exp(input int k, input int t, input int v, input int lim);
    if (t <= lim) exp_q.push_back('{k, t, v});
  endfunction

  // Expected events for nf back-to-back frames whose first load cycle is t0;
  // nothing after cycle lim (the abort cycle) is visible.
  function automatic void build_model(input int t0, input int nf, input int lim);
    exp_q.delete();
    for (int f = 0; f < nf; f++) begin
      int b;
      b = t0 + f * FL;
      for (int c = 0; c < LC; c++) add_exp(0, b + c, 0, lim);
      for (int j = 0; j < CL; j++) begin
        add_exp(1, b + LC + 2 * DV * j + DV - 1, j, lim);
        if (j < CL - 1) add_exp(2, b + LC + 2 * DV * j + DV, 0, lim);
      end
      add_exp(3, b + FL - 1, 0, lim);
    end
    add_exp(4, t0 + nf * FL, 0, lim);
  endfunction

  // Run nf frames (continuous drops inside the last one), optional abort at
  // abort_off cycles after the first load cycle, optional extra start pulse while busy.
  task automatic run(input int nf, input int abort_off, input bit repulse, input string tag);
    int cs, t0, abort_t, drop_t, endt, ne3;
    bit has_ab;
    logic [15:0] c0;
    c0 = frame_cnt;
    act_q.delete();
    @(negedge CLK);
    cs      = cyc;
    t0      = cs + 4;
    has_ab  = (abort_off >= 0);
    abort_t = has_ab ? t0 + abort_off : t0 + nf * FL + 100;
    drop_t  = t0 + (nf - 1) * FL + 5;
    endt    = t0 + nf * FL + 4;
    build_model(t0, nf, abort_t);
    start      = 1'b1;
    continuous = (nf > 1);
    while (cyc < endt) begin
      @(negedge CLK);
      if (cyc == cs + 3) start = 1'b0;
      if (repulse && cyc == t0 + 4) start = 1'b1;
      if (repulse && cyc == t0 + 6) start = 1'b0;
      if (cyc >= drop_t) continuous = 1'b0;
      abort = has_ab && (cyc == abort_t);
      if (has_ab && cyc == abort_t + 1)
        chk({tag, " outs after abort"},
            {load, shift_clk, sample_strb, save_data, busy, done, bit_idx}, 0);
    end
    abort = 1'b0; continuous = 1'b0; start = 1'b0;
    ne3 = 0;
    for (int k = 0; k < 5; k++) begin
      int na, ne;
      na = 0; ne = 0;
      foreach (act_q[i]) if (act_q[i].k == k) na++;
      foreach (exp_q[i]) if (exp_q[i].k == k) ne++;
      n_k[k] = na;
      if (k == 3) ne3 = ne;
      chk($sformatf("%s count kind%0d", tag, k), na, ne);
    end
    foreach (exp_q[i]) begin
      bit hit;
      hit = 1'b0;
      foreach (act_q[j])
        if (act_q[j].k == exp_q[i].k && act_q[j].t == exp_q[i].t && act_q[j].v == exp_q[i].v)
          hit = 1'b1;
      chk($sformatf("%s event k%0d t%0d v%0d", tag, exp_q[i].k, exp_q[i].t - t0, exp_q[i].v),
          hit, 1);
    end
    chk({tag, " busy at end"}, busy, 0);
    chk({tag, " frame_cnt"}, frame_cnt, 16'(c0 + 16'(ne3)));
  endtask

  typedef struct {
    int nf; int ab; bit rp;
    int n_load; int n_strb; int n_shift; int n_save; int n_done;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int cs, n_s, n_r, n_sv, n_d;
    logic sd1;

    // nf, abort offset, repulse, loads, strobes, shift rises, saves, dones
    tbl[0] = '{1, -1, 1'b1, 2, 4, 3, 1, 1};   // single frame, start re-pulsed while busy
    tbl[1] = '{3, -1, 1'b0, 6, 12, 9, 3, 1};  // continuous, dropped in third frame
    tbl[2] = '{1, 8, 1'b0, 2, 2, 2, 0, 0};    // abort in HIGH after bit 1
    tbl[3] = '{2, 16, 1'b0, 2, 4, 3, 1, 0};   // abort on the SAVE cycle in continuous mode
    tbl[4] = '{1, 0, 1'b0, 1, 0, 0, 0, 0};    // abort on first load cycle
    tbl[5] = '{1, 15, 1'b0, 2, 4, 3, 0, 0};   // abort on the last sample, beats SAVE

    RST = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset outs", {load, shift_clk, sample_strb, save_data, busy, done, bit_idx}, 0);
    chk("reset frame_cnt", frame_cnt, 0);
    chk("reset outs cl1", {load1, shift1, strb1, save1, busy1, done1, idx1}, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].nf, tbl[i].ab, tbl[i].rp, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d loads", i),  n_k[0], tbl[i].n_load);
      chk($sformatf("tbl%0d strobes", i), n_k[1], tbl[i].n_strb);
      chk($sformatf("tbl%0d shifts", i), n_k[2], tbl[i].n_shift);
      chk($sformatf("tbl%0d saves", i),  n_k[3], tbl[i].n_save);
      chk($sformatf("tbl%0d dones", i),  n_k[4], tbl[i].n_done);
      repeat (2) @(negedge CLK);
    end

    // Reset in the LOW phase of bit 2, then a clean frame.
    @(negedge CLK);
    cs = cyc;
    start = 1'b1;
    while (cyc < cs + 3) @(negedge CLK);
    start = 1'b0;
    while (cyc < cs + 4 + LC + 4 * DV) @(negedge CLK);
    chk("pre-reset bit_idx", bit_idx, 2);
    chk("pre-reset busy", busy, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid reset outs", {load, shift_clk, sample_strb, save_data, busy, done, bit_idx}, 0);
    chk("mid reset frame_cnt", frame_cnt, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    run(1, -1, 1'b0, "post-reset");
    chk("post-reset frame_cnt", frame_cnt, 1);

    // Single-bit chain: one strobe, no shift edges.
    n_s = 0; n_r = 0; n_sv = 0; n_d = 0; sd1 = 1'b0;
    @(negedge CLK);
    start1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i == 3) start1 = 1'b0;
      if (strb1) begin
        n_s++;
        chk("cl1 bit_idx", idx1, 0);
      end
      if (shift1 && !sd1) n_r++;
      sd1 = shift1;
      if (save1) n_sv++;
      if (done1) n_d++;
    end
    chk("cl1 strobes", n_s, 1);
    chk("cl1 shift rises", n_r, 0);
    chk("cl1 saves", n_sv, 1);
    chk("cl1 dones", n_d, 1);
    chk("cl1 frame_cnt", cnt1, 1);
    chk("cl1 busy", busy1, 0);

    // Randomized frames, aborts and ignored re-pulses.
    for (int it = 0; it < 20; it++) begin
      int nf, ab;
      bit rp;
      nf = $urandom_range(1, 3);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nf * FL - 1)) : -1;
      rp = (ab < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      repeat ($urandom_range(0, 4)) @(negedge CLK);
      run(nf, ab, rp, $sformatf("rand%0d", it));
    end

    // frame_cnt wrap from 0xFFFF.
    @(negedge CLK);
    force dut.cnt_q = 16'hFFFF;
    @(negedge CLK);
    release dut.cnt_q;
    @(negedge CLK);
    chk("wrap preload", frame_cnt, 16'hFFFF);
    run(1, -1, 1'b0, "wrap");
    chk("wrap result", frame_cnt, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_readout_seq.md
# piso_readout_seq

Generates the PISO control sequence (parallel load, then shift clock) that reads the test chip's DFF scan chains into the FPGA. It replaces direct Raspberry Pi bit-banging of load/shift. The block sits directly upstream of the DFF error-capture stage. It drives the chip-side load and shift pins and gives downstream logic a per-bit sample strobe, the bit index, and an end-of-frame save pulse.

## Interface
Parameters:
- CHAIN_LEN, 256: bits per scan chain per frame; must be >= 1.
- DIV, 4: CLK cycles per shift_clk half-period; must be >= 1.
- LOAD_CYCLES, 2: CLK cycles that load is held high; must be >= 1.
- IDX_W, clog2(CHAIN_LEN) (min 1): width of bit_idx.

Ports:
- CLK, in, 1: system clock. The block uses one clock; reset is synchronous and active-high.
- RST, in, 1: synchronous, active-high reset.
- start, in, 1: asynchronous request from the Pi. It is synchronized internally with 2 FFs; its rising edge requests a frame.
- continuous, in, 1: when high, frames repeat back-to-back until abort or until continuous goes low.
- abort, in, 1: synchronous abort, already in the CLK domain.
- load, out, 1: PISO parallel-load pin.
- shift_clk, out, 1: PISO shift clock pin.
- sample_strb, out, 1: one-cycle pulse; the chain outputs are valid for bit bit_idx.
- bit_idx, out, IDX_W: index of the bit being sampled.
- save_data, out, 1: one-cycle pulse after the last sample of a frame.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when the sequence ends normally.
- frame_cnt, out, 16: count of completed frames; wraps from 0xFFFF to 0.

## Operation
States: IDLE, LOAD, LOW, HIGH, SAVE, DONE.

- **IDLE**
  - All outputs are 0.
  - On a detected start rising edge, go to LOAD.
  - A start edge seen while busy is ignored and not queued.
- **LOAD**
  - load=1 for LOAD_CYCLES cycles, then go to LOW with k=0.
  - Bit 0 is present on the chain output after load.
- **LOW**
  - shift_clk=0 for DIV cycles.
  - On the last cycle: sample_strb=1 and bit_idx=k.
  - Then, if k<CHAIN_LEN-1, go to HIGH; otherwise go to SAVE.
- **HIGH**
  - shift_clk=1 for DIV cycles.
  - The rising edge at entry shifts the chain to bit k+1.
  - Then k increments and the state returns to LOW.
- **SAVE**
  - save_data=1 for one cycle; frame_cnt increments.
  - Then, if continuous=1 and abort=0, go to LOAD; otherwise go to DONE.
- **DONE**
  - done=1 for one cycle, then go to IDLE.
- **abort=1** in any state other than IDLE:
  - Next state is IDLE and all outputs return to their IDLE values.
  - No save_data, no done, and frame_cnt is unchanged.
  - abort takes priority over every other transition, including the SAVE exit.
- **RST** clears the state to IDLE, k to 0, frame_cnt to 0, the synchronizer flops, and every output, including in mid-frame.
- Exactly CHAIN_LEN sample_strb pulses and CHAIN_LEN-1 shift_clk rising edges occur per frame.
- When CHAIN_LEN=1, HIGH is never entered.

## Timing
- Every output is registered.
- All outputs reset to 0 (busy=0, bit_idx=0, frame_cnt=0).
- Start latency: the start edge is detected 3 CLK cycles after the pin rises (2 sync stages plus the edge register). LOAD is entered on the next cycle.
- Frame length in cycles: LOAD_CYCLES + CHAIN_LEN·DIV + (CHAIN_LEN-1)·DIV + 1 (the SAVE cycle).
- bit_idx is stable throughout each LOW phase. It changes only on the LOW→HIGH→LOW boundary.
- In continuous mode, the LOAD of frame n+1 starts on the cycle after SAVE of frame n; there is no gap.
- If continuous falls mid-frame, the current frame completes and then DONE follows.
- The k counter and the phase counter are independent. The phase counter is width clog2(max(DIV,LOAD_CYCLES)+1) and reloads on every state entry.

## Structure
- Shared package/header dff_test_pkg holds:
  - the state encodings (3-bit localparams);
  - the default CHAIN_LEN, DIV and LOAD_CYCLES constants, which the error-capture stage also uses.
- Sub-module sync_edge_detect holds the 2-FF synchronizer plus the rising-edge register with synchronous reset. It is reused for other Pi inputs.
- The FSM and counters stay in one module.

## Test plan
Unless noted, tests use CHAIN_LEN=4, DIV=2, LOAD_CYCLES=2.
- **Single frame:** pulse start.
  - Expect load high for 2 cycles.
  - Expect 4 sample_strb pulses with bit_idx 0,1,2,3.
  - Expect 3 shift_clk rising edges.
  - Expect save_data on frame cycle 17, then done on the next cycle.
  - Expect frame_cnt=1 and busy low after done.
- **Continuous mode:** continuous=1, then start; drop continuous during the third frame.
  - Expect exactly 3 save_data pulses, 17 cycles apart.
  - Expect one done, after the third frame.
  - Expect frame_cnt=3.
- **Abort:** assert abort during HIGH for bit 1.
  - Expect the next cycle to be IDLE with all outputs 0.
  - Expect no save_data and no done, and frame_cnt unchanged.
- **Reset mid-frame:** assert RST during LOW for bit 2.
  - Expect all outputs 0 on the next cycle.
  - Expect frame_cnt=0.
  - Expect a new start to produce a full, correct frame.
- **Ignored start:** re-pulse start while busy.
  - Expect no extra frame.
  - With CHAIN_LEN=1, expect 1 sample_strb and 0 shift_clk edges.
- **frame_cnt wrap:** preload frame_cnt=0xFFFF through a forced state, then run one frame.
  - Expect frame_cnt=0x0000.
